// File: rtl/program_loader_if.sv
// program_loader_if: program stream input and instruction-memory write port of the loader
interface program_loader_if #(
  parameter int AW = 2,
  parameter int IW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: streams a program into CPU instruction memory, pads unused slots with NOP,
// holds the CPU in reset until every slot is written. Define LOADER_CHECKSUM_EN to require
// a trailing XOR checksum word after the stream.
module program_loader #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int IW    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  program_loader_if.slave bus,
  output logic            o_cpu_reset,
  output logic            o_loaded,
  output logic            o_error
);
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CSUM, PAD, RUN} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, PAD, RUN} state_t;
`endif
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [IW-1:0] r_wr_data;
  logic          r_cpu_reset;
  logic          r_loaded;
  logic          r_error;
  logic          w_in_ready;
`ifdef LOADER_CHECKSUM_EN
  logic [IW-1:0] r_xor;
  logic          r_full;
  assign w_in_ready = (r_state == LOAD) || (r_state == CSUM);
`else
  assign w_in_ready = (r_state == LOAD);
`endif
  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_loaded     = r_loaded;
  assign o_error      = r_error;
  // Load FSM: start restarts from slot 0 (not during padding); writes are registered one cycle after accept
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_cpu_reset <= 1'b1;
      r_loaded    <= 1'b0;
      r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor       <= '0;
      r_full      <= 1'b0;
`endif
    end else if (i_start && r_state != PAD) begin
      r_state     <= LOAD;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_loaded    <= 1'b0;
      r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        LOAD: if (bus.in_valid) begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= bus.in_data;
          if (r_addr == LAST) r_error <= ~bus.in_last;
          if (r_addr != LAST) r_addr <= r_addr + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          r_xor <= r_xor ^ bus.in_data;
          if (r_addr == LAST || bus.in_last) begin
            r_state <= CSUM;
            r_full  <= (r_addr == LAST);
          end
`else
          if (r_addr == LAST || bus.in_last) r_state <= (r_addr == LAST) ? RUN : PAD;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: if (bus.in_valid) begin
          r_state <= (bus.in_data != r_xor) ? IDLE : (r_full ? RUN : PAD);
          if (bus.in_data != r_xor) r_error <= 1'b1;
        end
`endif
        PAD: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_addr;
          r_wr_data <= '0;
          if (r_addr == LAST) r_state <= RUN;
          else r_addr <= r_addr + 1'b1;
        end
        RUN: begin
          r_cpu_reset <= 1'b0;
          r_loaded    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
